// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer: combinational fetch lookup, resolve-stage updates.
// Optional per-entry 2-bit direction counter enabled by defining BTB_2BIT_CTR_EN.
module branch_target_buffer #(
    parameter int IDX_BITS = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] fetch_pc,
    output logic        btb_hit,
    output logic        predict_taken,
    output logic [15:0] predict_target,
    input  logic        btb_load,
    input  logic        upd_notaken,
    input  logic [15:0] upd_pc,
    input  logic [15:0] upd_target,
    input  logic        flush,
    output logic [15:0] lookup_cnt,
    output logic [15:0] hit_cnt
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = 15 - IDX_BITS;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [15:0]        target_q [ENTRIES];
`ifdef BTB_2BIT_CTR_EN
    logic [1:0]         ctr_q    [ENTRIES];
`endif

    logic [IDX_BITS-1:0] f_idx, u_idx;
    logic [TAG_W-1:0]    f_tag, u_tag;
    logic                u_hit;
    logic                unused_pc_bits;

    // Bit 0 of a PC never distinguishes branches, so it is dropped from index and tag.
    assign f_idx          = fetch_pc[IDX_BITS:1];
    assign f_tag          = fetch_pc[15:IDX_BITS+1];
    assign u_idx          = upd_pc[IDX_BITS:1];
    assign u_tag          = upd_pc[15:IDX_BITS+1];
    assign unused_pc_bits = fetch_pc[0] ^ upd_pc[0];

    assign btb_hit        = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign u_hit          = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
    assign predict_target = btb_hit ? target_q[f_idx] : 16'h0000;
`ifdef BTB_2BIT_CTR_EN
    assign predict_taken  = btb_hit & ctr_q[f_idx][1];
`else
    assign predict_taken  = btb_hit;
`endif

    // NOTE: sequential state uses non-blocking assignments so every entry and
    // counter updates from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= '0;
            lookup_cnt <= '0;
            hit_cnt    <= '0;
`ifdef BTB_2BIT_CTR_EN
            for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'b01;
`endif
        end else begin
            if (lookup_cnt != 16'hFFFF) lookup_cnt <= lookup_cnt + 16'd1;
            if (btb_hit && hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;

            // Flush beats updates; btb_load beats upd_notaken.
            if (flush) begin
                valid_q <= '0;
            end else if (btb_load) begin
                valid_q[u_idx] <= 1'b1;
`ifdef BTB_2BIT_CTR_EN
                if (!u_hit)                    ctr_q[u_idx] <= 2'b10;
                else if (ctr_q[u_idx] != 2'b11) ctr_q[u_idx] <= ctr_q[u_idx] + 2'd1;
`endif
            end else if (upd_notaken && u_hit) begin
`ifdef BTB_2BIT_CTR_EN
                if (ctr_q[u_idx] != 2'b00) ctr_q[u_idx] <= ctr_q[u_idx] - 2'd1;
`else
                valid_q[u_idx] <= 1'b0;
`endif
            end
        end
    end

    // NOTE: tag and target arrays carry no reset; valid_q alone decides whether
    // their contents mean anything, which keeps them plain RAM.
    always_ff @(posedge clk) begin
        if (!reset && !flush && btb_load) begin
            tag_q[u_idx]    <= u_tag;
            target_q[u_idx] <= upd_target;
        end
    end

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed self-checking bench for branch_target_buffer (IDX_BITS = 3).
// Counter checks follow BTB_2BIT_CTR_EN when it is defined for the build.
module tb_branch_target_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] fetch_pc;
    logic        btb_hit;
    logic        predict_taken;
    logic [15:0] predict_target;
    logic        btb_load;
    logic        upd_notaken;
    logic [15:0] upd_pc;
    logic [15:0] upd_target;
    logic        flush;
    logic [15:0] lookup_cnt;
    logic [15:0] hit_cnt;

    int vectors = 0;
    int errors  = 0;

    branch_target_buffer #(.IDX_BITS(3)) dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_pc       (fetch_pc),
        .btb_hit        (btb_hit),
        .predict_taken  (predict_taken),
        .predict_target (predict_target),
        .btb_load       (btb_load),
        .upd_notaken    (upd_notaken),
        .upd_pc         (upd_pc),
        .upd_target     (upd_target),
        .flush          (flush),
        .lookup_cnt     (lookup_cnt),
        .hit_cnt        (hit_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic look(input logic [15:0] pc, input string tag,
                        input logic hit, input logic taken, input logic [15:0] tgt);
        fetch_pc = pc;
        #1;
        check({tag, ".hit"},    {15'd0, btb_hit},       {15'd0, hit});
        check({tag, ".taken"},  {15'd0, predict_taken}, {15'd0, taken});
        check({tag, ".target"}, predict_target,         tgt);
    endtask

    task automatic load(input logic [15:0] pc, input logic [15:0] tgt, input int n = 1);
        btb_load = 1'b1; upd_pc = pc; upd_target = tgt;
        tick(n);
        btb_load = 1'b0;
    endtask

    task automatic notaken(input logic [15:0] pc, input int n = 1);
        upd_notaken = 1'b1; upd_pc = pc;
        tick(n);
        upd_notaken = 1'b0;
    endtask

    initial begin
        reset = 1'b1; fetch_pc = 16'h3000; btb_load = 1'b0; upd_notaken = 1'b0;
        upd_pc = 16'h0000; upd_target = 16'h0000; flush = 1'b0;

        // 1: reset state
        tick(2);
        look(16'h3000, "reset", 1'b0, 1'b0, 16'h0000);
        check("reset.lookup_cnt", lookup_cnt, 16'd0);
        check("reset.hit_cnt",    hit_cnt,    16'd0);
        reset = 1'b0;

        // 2: allocate and look up, pc[0] ignored
        load(16'h3004, 16'h3020);
        look(16'h3004, "alloc", 1'b1, 1'b1, 16'h3020);
        look(16'h3005, "alloc_bit0", 1'b1, 1'b1, 16'h3020);
        look(16'h3000, "alloc_other", 1'b0, 1'b0, 16'h0000);

        // not-taken on a miss at the same index changes nothing
        notaken(16'h3014);
        look(16'h3004, "notaken_miss", 1'b1, 1'b1, 16'h3020);

        // 3: direction behaviour
`ifdef BTB_2BIT_CTR_EN
        notaken(16'h3004, 3);                // 10 -> 01 -> 00 -> 00
        look(16'h3004, "ctr_floor", 1'b1, 1'b0, 16'h3020);
        load(16'h3004, 16'h3020);            // 00 -> 01
        look(16'h3004, "ctr_01", 1'b1, 1'b0, 16'h3020);
        load(16'h3004, 16'h3020, 4);         // 01 -> 10 -> 11 -> 11 -> 11
        look(16'h3004, "ctr_11", 1'b1, 1'b1, 16'h3020);
        notaken(16'h3004);                   // 11 -> 10
        look(16'h3004, "ctr_sat_10", 1'b1, 1'b1, 16'h3020);
        notaken(16'h3004);                   // 10 -> 01
        look(16'h3004, "ctr_sat_01", 1'b1, 1'b0, 16'h3020);
`else
        notaken(16'h3004);
        look(16'h3004, "evict", 1'b0, 1'b0, 16'h0000);
        load(16'h3004, 16'h3020);
`endif

        // 4: aliasing on index 2; a different index is unaffected
        load(16'h3002, 16'h3111);
        load(16'h3014, 16'h3040);
        look(16'h3004, "alias_old", 1'b0, 1'b0, 16'h0000);
        look(16'h3014, "alias_new", 1'b1, 1'b1, 16'h3040);
        look(16'h3002, "other_idx", 1'b1, 1'b1, 16'h3111);

        // 5: load + not-taken together acts as load (allocate, then on a hit)
        upd_notaken = 1'b1;
        load(16'h3004, 16'h3030);
        look(16'h3004, "both_alloc", 1'b1, 1'b1, 16'h3030);
        upd_notaken = 1'b1;
        load(16'h3004, 16'h3034);
        upd_notaken = 1'b0;
        look(16'h3004, "both_hit", 1'b1, 1'b1, 16'h3034);

        // flush with a same-cycle load: everything misses
        flush = 1'b1;
        load(16'h3008, 16'h3200);
        flush = 1'b0;
        look(16'h3004, "flush_a", 1'b0, 1'b0, 16'h0000);
        look(16'h3008, "flush_b", 1'b0, 1'b0, 16'h0000);
        look(16'h3002, "flush_c", 1'b0, 1'b0, 16'h0000);

        // 6: counters
        reset = 1'b1; fetch_pc = 16'h3000;
        tick();
        reset = 1'b0;
        load(16'h3004, 16'h3020);            // lookup 1, hit 0
        fetch_pc = 16'h3004;
        tick(1000);                          // lookup 1001, hit 1000
        check("cnt.lookup_1001", lookup_cnt, 16'd1001);
        check("cnt.hit_1000",    hit_cnt,    16'd1000);
        fetch_pc = 16'h3000;
        tick(65000);                         // lookup would be 66001 -> saturates
        check("cnt.lookup_sat", lookup_cnt, 16'hFFFF);
        check("cnt.hit_hold",   hit_cnt,    16'd1000);
        fetch_pc = 16'h3004;
        tick(3);
        check("cnt.lookup_stay", lookup_cnt, 16'hFFFF);
        check("cnt.hit_1003",    hit_cnt,    16'd1003);

        // reset mid-run dominates a same-cycle load and flush
        reset = 1'b1; flush = 1'b1;
        load(16'h3004, 16'h3050);
        flush = 1'b0;
        look(16'h3004, "midreset", 1'b0, 1'b0, 16'h0000);
        check("midreset.lookup_cnt", lookup_cnt, 16'd0);
        check("midreset.hit_cnt",    hit_cnt,    16'd0);
        reset = 1'b0;
        tick();
        look(16'h3004, "post_reset", 1'b0, 1'b0, 16'h0000);
        check("post_reset.lookup_cnt", lookup_cnt, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
